// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// The optional overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-position counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full-adder cell: the only arithmetic in the serial adder datapath.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic y,
    output logic cout
);

    assign y    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per cycle, LSB first, through serial_fa_cell.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             in_ready_s;
    logic             fa_y_s;
    logic             fa_cout_s;

    serial_fa_cell u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .y    (fa_y_s),
        .cout (fa_cout_s)
    );

    // A result taken in DONE frees the block in the same cycle, allowing back-to-back accepts.
    assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && out_ready);

    // Next-state, operand load and per-bit shift logic.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_sr_d = {fa_y_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_cout_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB, fa_cout_s the carry out of it.
                    ovf_d   = carry_q ^ fa_cout_s;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        a_sr_d  = a;
                        b_sr_d  = b;
                        carry_d = cin;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sr_q      <= {WIDTH{1'b0}};
            b_sr_q      <= {WIDTH{1'b0}};
            sum_sr_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_sr_q;
    assign cout      = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 64) begin
            tick;
            n++;
        end
    endtask

    // One complete transaction with optional backpressure cycles in DONE.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc, input int hold);
        logic [W:0] ref_v;
        int         sa, sb, sv, n;
        logic       eovf;
        ref_v = {1'b0, ta} + {1'b0, tbv} + {{W{1'b0}}, tc};
        sa = $signed(ta);
        sb = $signed(tbv);
        sv = sa + sb + (tc ? 1 : 0);
        eovf = (sv > 127) || (sv < -128);
        n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            tick;
            n++;
        end
        check("in_ready_idle", in_ready, 1);
        a = ta; b = tbv; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check("busy_run", busy, 1);
        check("in_ready_run", in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 64) begin
            out_ready = 1'($urandom);
            tick;
            n++;
        end
        out_ready = 1'b0;
        #1;
        check("latency", n, W);
        check("sum", sum, ref_v[W-1:0]);
        check("cout", cout, ref_v[W]);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, eovf);
`endif
        for (int h = 0; h < hold; h++) begin
            check("in_ready_hold", in_ready, 0);
            tick;
            check("out_valid_hold", out_valid, 1);
            check("sum_hold", sum, ref_v[W-1:0]);
            check("cout_hold", cout, ref_v[W]);
        end
        out_ready = 1'b1;
        #1;
        check("in_ready_take", in_ready, 1);
        tick;
        out_ready = 1'b0;
        check("out_valid_after_take", out_valid, 0);
        check("busy_after_take", busy, 0);
    endtask

    initial begin
        int          n, t0, t1;
        logic [W:0]  rv;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        tick; tick;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        tick;
        check("rst_in_ready", in_ready, 1);

        do_op(8'h5A, 8'h3C, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 1);
        do_op(8'hA5, 8'h5A, 1'b1, 5);
        do_op(8'h7F, 8'h01, 1'b0, 0);
        do_op(8'h80, 8'h80, 1'b0, 2);

        // Back-to-back: in_valid held high with out_ready high.
        a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        a = 8'h10; b = 8'h20;
        wait_out(n);
        t0 = cyc;
        check("b2b_latency0", n, W);
        check("b2b_sum0", sum, 8'h03);
        check("b2b_in_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_gap_valid", out_valid, 0);
        wait_out(n);
        t1 = cyc;
        check("b2b_sum1", sum, 8'h30);
        check("b2b_cout1", cout, 0);
        check("b2b_spacing", t1 - t0, W + 1);
        tick;
        out_ready = 1'b0;
        check("b2b_idle", busy, 0);

        // Reset during RUN discards the partial result.
        a = 8'h33; b = 8'h44; cin = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        check("midrst_busy", busy, 0);
        tick;
        rst_n = 1'b1;
        tick;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_still_idle", out_valid, 0);
        do_op(8'h0F, 8'h01, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, 1'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
